// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: ALU op codes and FSM state encodings.
package alu_pkg;

    localparam int unsigned OP_W = 4;
    localparam int unsigned ST_W = 2;

    localparam logic [OP_W-1:0] OP_AND = 4'd0;
    localparam logic [OP_W-1:0] OP_OR  = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB = 4'd6;
    localparam logic [OP_W-1:0] OP_SLT = 4'd7;
    localparam logic [OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [OP_W-1:0] OP_NOR = 4'd12;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_CALC = 2'd1;
    localparam logic [ST_W-1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/mult_iterativo.sv
// Shift-add multiplier: one partial product per cycle, fixed WIDTH-cycle latency after start.
module mult_iterativo #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] product_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             running_q;
    logic [WIDTH-1:0] acc_next;

    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // The last step's sum is handed out directly so the caller can register it on the same edge.
    assign done_c    = running_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_c = acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            mcand_q   <= a;
            mplier_q  <= b;
            acc_q     <= '0;
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done_c) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_registro_tr.sv
// Execute stage: single-cycle ALU plus optional iterative MUL, result held in TR until consumed.
// Build option: define ALU_TR_MUL_EN to implement op 8 (MUL); otherwise op 8 is unsupported.
module alu_registro_tr
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP_WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_WIDTH-1:0] ALU_OP,
    input  logic                IN_VALID,
    output logic                IN_READY,
    output logic [WIDTH-1:0]    TR,
    output logic                TR_VALID,
    input  logic                OUT_READY,
    output logic                OP_ERR,
    output logic                BUSY
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] tr_q, tr_d;
    logic             op_err_q, op_err_d;
    logic             tr_valid_q;
    logic             busy_q;
    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic             is_mul;
    logic             mul_done_c;
    logic [WIDTH-1:0] mul_product_c;

    assign IN_READY = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && OUT_READY);
    assign accept   = IN_VALID && IN_READY;

    // Single-cycle result and op-code decode
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        is_mul  = 1'b0;
        case (ALU_OP)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = WIDTH'($signed(A) < $signed(B));
            OP_NOR:  alu_res = ~(A | B);
`ifdef ALU_TR_MUL_EN
            OP_MUL:  is_mul  = 1'b1;
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tr_d     = tr_q;
        op_err_d = op_err_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d = ST_CALC;
                    end else begin
                        state_d  = ST_HOLD;
                        tr_d     = alu_res;
                        op_err_d = alu_err;
                    end
                end else if (state_q == ST_HOLD && OUT_READY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (mul_done_c) begin
                    state_d  = ST_HOLD;
                    tr_d     = mul_product_c;
                    op_err_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tr_q       <= '0;
            op_err_q   <= 1'b0;
            tr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tr_q       <= tr_d;
            op_err_q   <= op_err_d;
            tr_valid_q <= (state_d == ST_HOLD);
            busy_q     <= (state_d == ST_CALC);
        end
    end

    assign TR       = tr_q;
    assign OP_ERR   = op_err_q;
    assign TR_VALID = tr_valid_q;

`ifdef ALU_TR_MUL_EN
    logic mul_start;

    // Operands are latched by the multiplier on the accept edge
    assign mul_start = accept && is_mul;
    assign BUSY      = busy_q;

    mult_iterativo #(
        .WIDTH     (WIDTH)
    ) u_mult (
        .clk       (CLK),
        .rst       (RST),
        .start     (mul_start),
        .a         (A),
        .b         (B),
        .done_c    (mul_done_c),
        .product_c (mul_product_c)
    );
`else
    logic unused_busy;

    assign unused_busy   = busy_q;
    assign BUSY          = 1'b0;
    assign mul_done_c    = 1'b0;
    assign mul_product_c = '0;
`endif

endmodule

// File: tb/tb_alu_registro_tr.sv
// Scoreboard bench for alu_registro_tr: directed ops, backpressure, reset abort, bad op codes.
module tb_alu_registro_tr;

    logic        CLK;
    logic        RST;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_OP;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] TR;
    logic        TR_VALID;
    logic        OUT_READY;
    logic        OP_ERR;
    logic        BUSY;

    typedef struct {
        logic [31:0] tr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alu_registro_tr #(.WIDTH(32), .OP_WIDTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .A         (A),
        .B         (B),
        .ALU_OP    (ALU_OP),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .TR        (TR),
        .TR_VALID  (TR_VALID),
        .OUT_READY (OUT_READY),
        .OP_ERR    (OP_ERR),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result is compared against the oldest expectation
    always @(negedge CLK) begin
        if (!RST && TR_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h expected none", TR);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_tr", TR, e.tr);
                check("sb_op_err", 32'(OP_ERR), 32'(e.err));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input logic [31:0] etr, input logic eerr, input bit push);
        bit ok;
        exp_t e;
        ok       = 1'b0;
        A        = a;
        B        = b;
        ALU_OP   = op;
        IN_VALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (IN_READY) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'(IN_READY), 32'd1);
        if (push) begin
            e.tr  = etr;
            e.err = eerr;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Result must be visible in the cycle right after accept
    task automatic check_lat1(input string name);
        @(negedge CLK);
        check(name, 32'(TR_VALID), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_tr", TR, 32'h0);
        check("rst_tr_valid", 32'(TR_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_op_err", 32'(OP_ERR), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        A         = '0;
        B         = '0;
        ALU_OP    = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("init_in_ready", 32'(IN_READY), 32'd1);
        check("init_tr_valid", 32'(TR_VALID), 32'd0);
        @(posedge CLK);
        #1;

        // Reset while a result is held
        OUT_READY = 1'b0;
        issue(32'd3, 32'd4, 4'd2, 32'd7, 1'b0, 1'b0);
        @(negedge CLK);
        check("held_tr", TR, 32'd7);
        pulse_reset();
        OUT_READY = 1'b1;
        @(negedge CLK);
        check("post_rst_in_ready", 32'(IN_READY), 32'd1);
        check("post_rst_tr_valid", 32'(TR_VALID), 32'd0);
        @(posedge CLK);
        #1;

        // ADD wrap
        issue(32'hFFFF_FFFF, 32'd1, 4'd2, 32'h0, 1'b0, 1'b1);
        check_lat1("add_latency");
        @(posedge CLK);
        #1;

        // SLT signed then SUB, back to back
        issue(32'hFFFF_FFFE, 32'd1, 4'd7, 32'd1, 1'b0, 1'b1);
        issue(32'd5, 32'd5, 4'd6, 32'd0, 1'b0, 1'b1);
        check_lat1("sub_latency");
        @(posedge CLK);
        #1;

        // Backpressure: OR held, pending AND ignored while not ready
        OUT_READY = 1'b0;
        issue(32'h0000_00F0, 32'h0000_000F, 4'd1, 32'h0000_00FF, 1'b0, 1'b1);
        A        = 32'hFF00_FF00;
        B        = 32'h0FF0_0FF0;
        ALU_OP   = 4'd0;
        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_tr", TR, 32'h0000_00FF);
            check("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        @(posedge CLK);
        #1;
        OUT_READY = 1'b1;
        issue(32'hFF00_FF00, 32'h0FF0_0FF0, 4'd0, 32'h0F00_0F00, 1'b0, 1'b1);
        check_lat1("b2b_and_valid");
        check("b2b_and_tr", TR, 32'h0F00_0F00);
        @(posedge CLK);
        #1;
        issue(32'h0, 32'h0, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b1);
        check_lat1("nor_valid");
        @(posedge CLK);
        #1;

        // Unsupported op code
        issue(32'h1234_5678, 32'h1, 4'd15, 32'h0, 1'b1, 1'b1);
        check_lat1("bad_op_latency");
        @(posedge CLK);
        #1;
        issue(32'h1, 32'h2, 4'd1, 32'h3, 1'b0, 1'b1);
        @(posedge CLK);
        #1;

`ifdef ALU_TR_MUL_EN
        // Iterative MUL: fixed latency regardless of operand values
        for (int k = 0; k < 2; k++) begin
            int busy_cnt;
            int seen;
            busy_cnt = 0;
            seen     = -1;
            if (k == 0) issue(32'h0001_0001, 32'h0001_0001, 4'd8, 32'h0002_0001, 1'b0, 1'b1);
            else        issue(32'h0, 32'h5, 4'd8, 32'h0, 1'b0, 1'b1);
            for (int i = 0; i < 40; i++) begin
                @(negedge CLK);
                if (TR_VALID) begin
                    seen = i;
                    break;
                end
                if (BUSY) busy_cnt++;
            end
            check("mul_busy_cycles", 32'(busy_cnt), 32'd32);
            check("mul_latency", 32'(seen), 32'd32);
            @(posedge CLK);
            #1;
        end
        // Abort mid-CALC
        issue(32'd3, 32'd3, 4'd8, 32'd9, 1'b0, 1'b0);
        repeat (9) @(posedge CLK);
        pulse_reset();
        repeat (40) begin
            @(negedge CLK);
            if (TR_VALID) break;
        end
        check("abort_no_result", 32'(TR_VALID), 32'd0);
        @(posedge CLK);
        #1;
`else
        // MUL not built: behaves as an unsupported op
        issue(32'h0001_0001, 32'h0001_0001, 4'd8, 32'h0, 1'b1, 1'b1);
        @(negedge CLK);
        check("mul_off_latency", 32'(TR_VALID), 32'd1);
        check("mul_off_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
`endif

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
